// File: rtl/param_cache.sv
// Direct-mapped, write-through / write-allocate word cache with a narrow memory bus.
// CPU words move to/from memory as little-endian beats; read hit/miss statistics saturate.
module param_cache #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 8,
  parameter int MEM_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  input  logic              WE,
  input  logic              RREQ,
  output logic [DATA_W-1:0] DOUT,
  output logic              RDY,
  output logic [ADDR_W-1:0] MADDR,
  output logic [MEM_W-1:0]  MDOUT,
  input  logic [MEM_W-1:0]  MDIN,
  output logic              MREQ,
  output logic              MWE,
  input  logic              MRDY,
  output logic [CNT_W-1:0]  HIT_CNT,
  output logic [CNT_W-1:0]  MISS_CNT,
  output logic [1:0]        DBG_STATE
);

  // Memory handshake: MREQ is held with MADDR/MWE/MDOUT stable until MRDY is
  // sampled high on a rising edge; that edge completes the beat (and latches MDIN
  // on reads). The next beat's address appears on the following cycle.

  localparam int BEATS      = DATA_W / MEM_W;
  localparam int OFF        = $clog2(DATA_W / 8);
  localparam int IDX        = $clog2(LINES);
  localparam int TAG_W      = ADDR_W - OFF - IDX;
  localparam int BCW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BYTES = MEM_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((64'd1 << OFF) - 64'd1));

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  din_q;
  logic [DATA_W-1:0]  fill_q;
  logic [DATA_W-1:0]  fill_next;
  logic [DATA_W-1:0]  dout_q;
  logic [BCW-1:0]     beat_q;
  logic [CNT_W-1:0]   hit_q;
  logic [CNT_W-1:0]   miss_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [DATA_W-1:0]  data_mem [LINES];

  logic [IDX-1:0]     req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX-1:0]     op_idx;
  logic [TAG_W-1:0]   op_tag;
  logic               req_hit;
  logic               last_beat;
  logic [MEM_W-1:0]   beat_wdata;

  logic               line_we;
  logic [IDX-1:0]     line_idx;
  logic [TAG_W-1:0]   line_tag;
  logic [DATA_W-1:0]  line_data;

  assign req_idx   = ADDR[OFF+IDX-1:OFF];
  assign req_tag   = ADDR[ADDR_W-1:OFF+IDX];
  assign op_idx    = addr_q[OFF+IDX-1:OFF];
  assign op_tag    = addr_q[ADDR_W-1:OFF+IDX];
  assign req_hit   = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_beat = (beat_q == BCW'(BEATS - 1));

  // Beat k occupies bits [MEM_W*k +: MEM_W] of the word in both directions.
  always_comb begin
    fill_next  = fill_q;
    beat_wdata = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BCW'(k)) begin
        fill_next[k*MEM_W +: MEM_W] = MDIN;
        beat_wdata                  = din_q[k*MEM_W +: MEM_W];
      end
    end
  end

  // A line is written at write acceptance (allocate) or on the final fill beat.
  always_comb begin
    line_we   = 1'b0;
    line_idx  = req_idx;
    line_tag  = req_tag;
    line_data = DIN;
    if (state_q == IDLE && WE) begin
      line_we = 1'b1;
    end else if (state_q == FILL && MRDY && last_beat) begin
      line_we   = 1'b1;
      line_idx  = op_idx;
      line_tag  = op_tag;
      line_data = fill_next;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (WE) begin
          state_d = WRITE;
        end else if (RREQ) begin
          state_d = req_hit ? DONE : FILL;
        end
      end
      FILL, WRITE: begin
        if (MRDY && last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      valid_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      fill_q  <= '0;
      dout_q  <= '0;
      beat_q  <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      if (line_we) valid_q[line_idx] <= 1'b1;
      case (state_q)
        IDLE: begin
          if (WE || RREQ) begin
            addr_q <= ADDR & ALIGN_MASK;
            din_q  <= DIN;
            beat_q <= '0;
            fill_q <= '0;
            // A simultaneous read is dropped in favour of the write.
            if (!WE) begin
              if (req_hit) begin
                dout_q <= data_mem[req_idx];
                if (hit_q != '1) hit_q <= hit_q + CNT_W'(1);
              end else begin
                if (miss_q != '1) miss_q <= miss_q + CNT_W'(1);
              end
            end
          end
        end
        FILL: begin
          if (MRDY) begin
            fill_q <= fill_next;
            beat_q <= beat_q + BCW'(1);
            if (last_beat) dout_q <= fill_next;
          end
        end
        WRITE: begin
          if (MRDY) beat_q <= beat_q + BCW'(1);
        end
        default: ;
      endcase
    end
  end

  // Tag/data storage needs no reset; the valid bits guard it.
  always_ff @(posedge CLK) begin
    if (RST && line_we) begin
      tag_mem[line_idx]  <= line_tag;
      data_mem[line_idx] <= line_data;
    end
  end

  assign MREQ      = (state_q == FILL) || (state_q == WRITE);
  assign MWE       = (state_q == WRITE);
  assign MADDR     = MREQ ? (addr_q + ADDR_W'(beat_q) * ADDR_W'(BEAT_BYTES)) : '0;
  assign MDOUT     = MWE ? beat_wdata : '0;
  assign RDY       = (state_q == DONE);
  assign DOUT      = dout_q;
  assign HIT_CNT   = hit_q;
  assign MISS_CNT  = miss_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_param_cache.sv
// Bench for param_cache: byte-wide memory responder, cache/counter model and
// scoreboard queues for completed reads and for every memory beat.
module tb_param_cache;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINES  = 8;
  localparam int MEM_W  = 8;
  localparam int CNT_W  = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [ADDR_W-1:0] ADDR = '0;
  logic [DATA_W-1:0] DIN = '0;
  logic              WE = 1'b0;
  logic              RREQ = 1'b0;
  logic [DATA_W-1:0] DOUT;
  logic              RDY;
  logic [ADDR_W-1:0] MADDR;
  logic [MEM_W-1:0]  MDOUT;
  logic [MEM_W-1:0]  MDIN = '0;
  logic              MREQ;
  logic              MWE;
  logic              MRDY = 1'b0;
  logic [CNT_W-1:0]  HIT_CNT;
  logic [CNT_W-1:0]  MISS_CNT;
  logic [1:0]        DBG_STATE;

  param_cache #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .MEM_W(MEM_W), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DIN(DIN), .WE(WE), .RREQ(RREQ),
    .DOUT(DOUT), .RDY(RDY), .MADDR(MADDR), .MDOUT(MDOUT), .MDIN(MDIN),
    .MREQ(MREQ), .MWE(MWE), .MRDY(MRDY), .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT),
    .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]        mem [4096];
  logic              mvalid [LINES];
  logic [26:0]       mtag [LINES];
  int                exp_hit;
  int                exp_miss;
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_w_q[$];
  logic [40:0]       exp_beat_q[$];

  bit                seen;
  bit                mreq_seen;
  int                stall_left;
  int                stall_n;
  logic [31:0]       stall_addr = 32'hFFFF_FFFF;
  logic [31:0]       stall_ref;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int b;
    b = int'(a[11:0]) & 32'hFFC;
    return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  endfunction

  function automatic int sat(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Memory responder: MRDY rises one cycle after a beat request is seen,
  // optionally stretched for the beat at stall_addr.
  always @(negedge CLK) begin
    logic [40:0] got_beat;
    if (MREQ === 1'b1) mreq_seen = 1'b1;
    if (MREQ !== 1'b1) begin
      seen = 1'b0;
      MRDY = 1'b0;
      stall_left = 0;
    end else if (!seen) begin
      seen = 1'b1;
      MRDY = 1'b0;
      if (MADDR == stall_addr) begin
        stall_left = stall_n;
        stall_ref  = MADDR;
        stall_addr = 32'hFFFF_FFFF;
      end
    end else if (stall_left > 0) begin
      stall_left--;
      MRDY = 1'b0;
      check_eq("stall_maddr", 64'(MADDR), 64'(stall_ref));
      check_eq("stall_rdy", 64'(RDY), 64'd0);
    end else begin
      MRDY = 1'b1;
      seen = 1'b0;
      got_beat = {MWE, MADDR, MDOUT};
      if (MWE) mem[MADDR[11:0]] = MDOUT;
      else     MDIN = mem[MADDR[11:0]];
      if (exp_beat_q.size() == 0) check_eq("beat_extra", 64'(got_beat), 64'd0);
      else check_eq("beat", 64'(got_beat), 64'(exp_beat_q.pop_front()));
    end
  end

  // Completion monitor: each RDY pops one expected result.
  always @(negedge CLK) begin
    logic [DATA_W-1:0] d;
    logic w;
    if (RDY === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("rdy_extra", 64'd1, 64'd0);
      end else begin
        d = exp_q.pop_front();
        w = exp_w_q.pop_front();
        if (!w) check_eq("dout", 64'(DOUT), 64'(d));
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
    exp_q.delete();
    exp_w_q.delete();
    exp_beat_q.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0; WE = 1'b0; RREQ = 1'b0;
    @(negedge CLK);
    check_eq("rst_rdy", 64'(RDY), 64'd0);
    check_eq("rst_dout", 64'(DOUT), 64'd0);
    check_eq("rst_mreq", 64'(MREQ), 64'd0);
    check_eq("rst_mwe", 64'(MWE), 64'd0);
    check_eq("rst_maddr", 64'(MADDR), 64'd0);
    check_eq("rst_mdout", 64'(MDOUT), 64'd0);
    check_eq("rst_hit", 64'(HIT_CNT), 64'd0);
    check_eq("rst_miss", 64'(MISS_CNT), 64'd0);
    RST = 1'b1;
    clear_model();
  endtask

  task automatic wait_done(input int exp_lat, input string name);
    int cyc;
    cyc = 0;
    while (RDY !== 1'b1 && cyc < 300) begin
      @(negedge CLK);
      cyc++;
    end
    if (RDY !== 1'b1) check_eq({name, "_timeout"}, 64'd0, 64'd1);
    else check_eq({name, "_lat"}, 64'(cyc), 64'(exp_lat));
    @(negedge CLK);
    check_eq({name, "_rdy_pulse"}, 64'(RDY), 64'd0);
    check_eq({name, "_hit_cnt"}, 64'(HIT_CNT), 64'(exp_hit));
    check_eq({name, "_miss_cnt"}, 64'(MISS_CNT), 64'(exp_miss));
  endtask

  // driver tasks: called at a negedge with the DUT idle
  task automatic do_read(input logic [31:0] a, input int extra);
    logic [31:0] al;
    int idx;
    bit hit;
    al  = a & 32'hFFFF_FFFC;
    idx = int'(a[4:2]);
    hit = mvalid[idx] && (mtag[idx] == a[31:5]);
    exp_q.push_back(mem_word(a));
    exp_w_q.push_back(1'b0);
    if (hit) begin
      exp_hit = sat(exp_hit + 1);
    end else begin
      exp_miss = sat(exp_miss + 1);
      for (int k = 0; k < 4; k++) exp_beat_q.push_back({1'b0, al + 32'(k), 8'h00});
      mvalid[idx] = 1'b1;
      mtag[idx]   = a[31:5];
    end
    mreq_seen = 1'b0;
    ADDR = a; DIN = $urandom; RREQ = 1'b1; WE = 1'b0;
    @(negedge CLK);
    RREQ = 1'b0; ADDR = $urandom; DIN = $urandom;
    wait_done(hit ? 0 : 8 + extra, "rd");
    if (hit) check_eq("rd_hit_mreq", 64'(mreq_seen), 64'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both);
    logic [31:0] al;
    int idx;
    al  = a & 32'hFFFF_FFFC;
    idx = int'(a[4:2]);
    for (int k = 0; k < 4; k++) exp_beat_q.push_back({1'b1, al + 32'(k), d[8*k +: 8]});
    exp_q.push_back(d);
    exp_w_q.push_back(1'b1);
    mvalid[idx] = 1'b1;
    mtag[idx]   = a[31:5];
    ADDR = a; DIN = d; WE = 1'b1; RREQ = both;
    @(negedge CLK);
    WE = 1'b0; RREQ = 1'b0; ADDR = $urandom; DIN = $urandom;
    wait_done(8, "wr");
  endtask

  // Requests pulsed while a fill beat is stalled must be ignored.
  task automatic stall_noise();
    int w;
    w = 0;
    while (stall_left == 0 && w < 60) begin
      @(negedge CLK);
      w++;
    end
    check_eq("stall_reached", 64'(w < 60), 64'd1);
    ADDR = 32'h1C4; DIN = 32'h0BAD_0BAD; WE = 1'b1; RREQ = 1'b1;
    @(negedge CLK);
    WE = 1'b0; RREQ = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int w;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    clear_model();
    do_reset();

    do_read(32'h100, 0);
    do_read(32'h100, 0);
    do_write(32'h120, 32'hDEAD_BEEF, 1'b0);
    do_read(32'h120, 0);
    do_read(32'h100, 0);

    do_reset();
    stall_addr = 32'h102;
    stall_n    = 5;
    fork
      do_read(32'h100, 5);
      stall_noise();
    join
    do_read(32'h1C4, 0);

    // reset in the middle of a fill
    exp_beat_q.push_back({1'b0, 32'h108, 8'h00});
    ADDR = 32'h108; RREQ = 1'b1;
    @(negedge CLK);
    RREQ = 1'b0;
    w = 0;
    while (!(MREQ === 1'b1 && MADDR === 32'h109) && w < 40) begin
      @(negedge CLK);
      w++;
    end
    check_eq("rstfill_reach", 64'(w < 40), 64'd1);
    RST = 1'b0;
    @(negedge CLK);
    check_eq("rstfill_mreq", 64'(MREQ), 64'd0);
    check_eq("rstfill_rdy", 64'(RDY), 64'd0);
    check_eq("rstfill_hit", 64'(HIT_CNT), 64'd0);
    check_eq("rstfill_miss", 64'(MISS_CNT), 64'd0);
    check_eq("rstfill_maddr", 64'(MADDR), 64'd0);
    RST = 1'b1;
    clear_model();
    do_read(32'h108, 0);

    do_write(32'h140, 32'hCAFE_F00D, 1'b1);
    for (int i = 0; i < 4; i++) do_read(32'h140, 0);

    for (int i = 0; i < 24; i++) begin
      a = 32'h200 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 1) << 5);
      if ($urandom_range(0, 2) == 0) do_write(a, $urandom, 1'($urandom_range(0, 1)));
      else do_read(a, 0);
    end

    check_eq("exp_q_left", 64'(exp_q.size()), 64'd0);
    check_eq("beat_q_left", 64'(exp_beat_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_cache.md
PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, CPU/memory address width; DATA_W, default 32, CPU word width; LINES, default 8, direct-mapped line count (power of 2, >= 2); MEM_W, default 8, memory bus width (multiple of 8, divides DATA_W); CNT_W, default 16, statistics counter width.
REQ-002 Derived constants SHALL be: BEATS = DATA_W/MEM_W; OFF = log2(DATA_W/8); IDX = log2(LINES); tag = ADDR[ADDR_W-1:OFF+IDX]; index = ADDR[OFF+IDX-1:OFF].
REQ-003 Ports SHALL be:
CLK  in  1  sole clock, rising edge
RST  in  1  synchronous, active-low reset
ADDR  in  ADDR_W  CPU byte address (low OFF bits ignored)
DIN  in  DATA_W  CPU write data
WE  in  1  write request
RREQ  in  1  read request
DOUT  out  DATA_W  read data, valid while RDY=1
RDY  out  1  one-cycle completion pulse
MADDR  out  ADDR_W  memory byte address
MDOUT  out  MEM_W  memory write data
MDIN  in  MEM_W  memory read data
MREQ  out  1  memory beat request
MWE  out  1  memory beat is a write
MRDY  in  1  memory beat accepted/data valid
HIT_CNT  out  CNT_W  read hits since reset
MISS_CNT  out  CNT_W  read misses since reset

Function
REQ-004 The FSM SHALL have states IDLE, FILL, WRITE, DONE; requests SHALL be sampled only in IDLE and ignored in all other states.
REQ-005 ADDR and DIN SHALL be latched at acceptance; later changes SHALL not affect the operation.
REQ-006 If WE and RREQ are both high in IDLE, the write SHALL be performed and the read dropped.
REQ-007 Read hit (line valid, tag equal): IDLE->DONE; DOUT = line data and RDY=1 in the cycle after acceptance; no MREQ; HIT_CNT +1.
REQ-008 Read miss: IDLE->FILL; MISS_CNT +1; beats k = 0..BEATS-1 fetched in ascending order.
REQ-009 Each beat SHALL drive MREQ=1, MADDR = aligned address + k*(MEM_W/8), MWE and MDOUT held stable until MRDY is sampled high; that cycle completes the beat, and the next beat's address is driven on the following cycle.
REQ-010 Fill data SHALL be little-endian: MDIN of beat k goes to bits [MEM_W*k +: MEM_W]; after the last beat the line SHALL be written with data and tag, marked valid, and the FSM SHALL go to DONE with DOUT = filled word.
REQ-011 Write (write-through, write-allocate): at acceptance the indexed line SHALL be overwritten with DIN and tag and marked valid; IDLE->WRITE; BEATS beats with MWE=1, MDOUT = DIN[MEM_W*k +: MEM_W]; after the last MRDY go to DONE; DOUT undefined in write DONE.
REQ-012 DONE SHALL last exactly one cycle with RDY=1, then IDLE; RDY SHALL be 0 in all other states, so a new request is acceptable one cycle after RDY.
REQ-013 MREQ and MWE SHALL be 0 outside FILL/WRITE; MDOUT SHALL be 0 when MWE=0.
REQ-014 HIT_CNT and MISS_CNT SHALL saturate at all-ones and not wrap; writes SHALL not change either counter.
REQ-015 No timeout on MRDY: a stalled beat SHALL be held indefinitely.

Reset
REQ-016 With RST=0 at a rising edge, regardless of state: FSM=IDLE, all valid bits=0, RDY=0, DOUT=0, MREQ=0, MWE=0, MADDR=0, MDOUT=0, HIT_CNT=0, MISS_CNT=0, effective that edge.
REQ-017 A reset during FILL/WRITE SHALL abandon the operation with no RDY pulse; the partially filled line SHALL remain invalid.

Verification (LINES=8, DATA_W=32, MEM_W=8, memory MRDY one cycle after MREQ)
REQ-018 Reset, read 0x100, memory bytes 0x11,0x22,0x33,0x44 at 0x100..0x103 -> four read beats at MADDR 0x100..0x103, DOUT=0x44332211 with single-cycle RDY, MISS_CNT=1.
REQ-019 Read 0x100 again -> RDY and DOUT=0x44332211 one cycle after request, MREQ stays 0, HIT_CNT=1.
REQ-020 Write 0xDEADBEEF to 0x120 (same index 0) -> write beats 0xEF,0xBE,0xAD,0xDE to 0x120..0x123, one RDY; read 0x120 hits with 0xDEADBEEF; read 0x100 then misses.
REQ-021 MRDY held low 5 cycles on beat 2 of a fill -> MREQ=1, MADDR=0x102 stable throughout, RDY=0 until completion; RREQ/WE pulsed during the stall are ignored.
REQ-022 RST=0 during beat 1 of a fill -> next cycle MREQ=0, RDY=0, counters 0; subsequent read of same address misses.
REQ-023 WE and RREQ both high to 0x140 -> write-only sequence, MISS_CNT and HIT_CNT unchanged; with CNT_W=2, four hits -> HIT_CNT stays at 3.
